sc_out_collector: RTL and testbench

SC_OUT_COLLECTOR -- requirements
Module: sc_out_collector

---
 rtl/sc_out_collector.sv | 177 +++++++++++++++++
 tb/tb_sc_out_collector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_out_collector.sv
// sc_out_collector
//   Collects UNROLL_FACTOR-word beats from a stencil engine into complete
//   output rows (OCOL words each) and presents them one row at a time on a
//   valid/ready port. A separate fill buffer keeps accepting beats while up
//   to two finished rows wait in a small FIFO. The engine cannot be stalled,
//   so a row that finishes while the FIFO is full (and nothing is leaving)
//   is dropped and the sticky overflow flag is raised.
//
// Ports
//   clock         sole clock, rising edge
//   reset         synchronous, active-low
//   frame_start   one-cycle pulse, restarts collection of a frame
//   io_out_valid  engine beat valid (no back-pressure)
//   io_out_data   engine beat, word k at [k*BW +: BW]
//   m_valid       a completed row is presented
//   m_ready       downstream accepts the presented row
//   m_data        row words, column c at [c*BW +: BW]
//   m_row         index of the presented row
//   m_last        presented row is the final row of the frame
//   frame_done    high in the cycle the final row is accepted
//   overflow      sticky: a beat or a whole row was dropped
//
// State | meaning
//   IDLE  | no frame active; beats are dropped and flagged
//   FILL  | assembling rows of the current frame
//   DRAIN | all rows assembled; waiting for the last row to be accepted
module sc_out_collector #(
  parameter int BW            = 32,
  parameter int UNROLL_FACTOR = 2,
  parameter int ROW           = 8,
  parameter int COL           = 8,
  parameter int RADIUS        = 1,
  localparam int OROW         = ROW - 2*RADIUS,
  localparam int OCOL         = COL - 2*RADIUS,
  localparam int RW           = (OROW > 1) ? $clog2(OROW) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        io_out_valid,
  input  logic [UNROLL_FACTOR*BW-1:0] io_out_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [OCOL*BW-1:0]          m_data,
  output logic [RW-1:0]               m_row,
  output logic                        m_last,
  output logic                        frame_done,
  output logic                        overflow
);

  localparam int CW = $clog2(OCOL + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CW-1:0]       r_col_cnt;
  logic [RW-1:0]       r_row_cnt;
  logic [OCOL*BW-1:0]  r_fill;
  logic [OCOL*BW-1:0]  r_fifo_data [2];
  logic [RW-1:0]       r_fifo_row  [2];
  logic                r_rd_ptr;
  logic [1:0]          r_cnt;
  logic                r_overflow;

  logic                w_pop;
  logic                w_beat;
  logic                w_stray;
  logic                w_row_done;
  logic                w_push;
  logic                w_drop;
  logic                w_last_row;
  logic                w_wr_idx;
  logic [OCOL*BW-1:0]  w_fill_nxt;

  always_comb begin
    w_pop      = (r_cnt != 2'd0) && m_ready;
    w_beat     = io_out_valid && !frame_start && (r_state == S_FILL);
    w_stray    = io_out_valid && !frame_start && (r_state != S_FILL);
    w_row_done = w_beat && (r_col_cnt == CW'(OCOL - UNROLL_FACTOR));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    w_push     = w_row_done && ((r_cnt != 2'd2) || w_pop);
    w_drop     = w_row_done && !w_push;
    w_last_row = (r_row_cnt == RW'(OROW - 1));
    // Write slot is the one after the head; when full it is the slot being
    // popped, which is exactly the slot that frees up.
    w_wr_idx   = r_rd_ptr ^ r_cnt[0];
  end

  // Fill buffer with the current beat merged in; this is also the row that
  // gets committed when the beat completes it.
  always_comb begin
    w_fill_nxt = r_fill;
    for (int c = 0; c < OCOL; c++) begin
      for (int k = 0; k < UNROLL_FACTOR; k++) begin
        if (int'(r_col_cnt) + k == c) begin
          w_fill_nxt[c*BW +: BW] = io_out_data[k*BW +: BW];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = S_FILL;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_FILL:  if (w_row_done && w_last_row) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_pop && m_last) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
      r_overflow <= 1'b0;
    end else if (frame_start) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_beat) begin
        r_col_cnt <= w_row_done ? '0 : r_col_cnt + CW'(UNROLL_FACTOR);
      end
      // Row index advances even for a dropped row so the gap is visible.
      if (w_row_done) begin
        r_row_cnt <= r_row_cnt + RW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_drop || w_stray) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Data storage carries no reset; validity is tracked by r_cnt alone.
  always_ff @(posedge clock) begin
    if (w_beat) begin
      r_fill <= w_fill_nxt;
    end
    if (w_push) begin
      r_fifo_data[w_wr_idx] <= w_fill_nxt;
      r_fifo_row[w_wr_idx]  <= r_row_cnt;
    end
  end

  always_comb begin
    m_valid    = (r_cnt != 2'd0);
    m_data     = m_valid ? r_fifo_data[r_rd_ptr] : '0;
    m_row      = m_valid ? r_fifo_row[r_rd_ptr] : '0;
    m_last     = m_valid && (r_fifo_row[r_rd_ptr] == RW'(OROW - 1));
    frame_done = m_valid && m_ready && m_last;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_sc_out_collector.sv
// Testbench for sc_out_collector: a queue-based reference model is advanced
// on every rising edge and the DUT outputs are compared against it on every
// falling edge. Directed frames pin specific literal outcomes; a randomized
// phase then exercises frame_start/reset/stall interleavings.
module tb_sc_out_collector;

  localparam int BW     = 32;
  localparam int UF     = 2;
  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int RADIUS = 1;
  localparam int OROW   = ROW - 2*RADIUS;
  localparam int OCOL   = COL - 2*RADIUS;
  localparam int DW     = OCOL*BW;
  localparam int RW     = $clog2(OROW);

  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_DRAIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            fs;
  logic            ov;
  logic [UF*BW-1:0] od;
  logic            rdy;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [RW-1:0]   m_row;
  logic            m_last;
  logic            frame_done;
  logic            overflow;

  sc_out_collector #(
    .BW(BW), .UNROLL_FACTOR(UF), .ROW(ROW), .COL(COL), .RADIUS(RADIUS)
  ) dut (
    .clock(clk), .reset(rst_n), .frame_start(fs),
    .io_out_valid(ov), .io_out_data(od),
    .m_valid(m_valid), .m_ready(rdy), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .frame_done(frame_done), .overflow(overflow)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            row;
  } row_t;

  // reference model state
  row_t         mq[$];
  logic [BW-1:0] m_fill [OCOL];
  int           m_st = M_IDLE;
  int           m_col = 0;
  int           m_rowc = 0;
  bit           m_ovf = 1'b0;

  // observation
  row_t log_q[$];
  int   cyc = 0;
  int   fs_cyc = -1;
  int   handled_fs = -1;
  int   first_lat = -1;
  int   fd_cnt = 0;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit   pop;
    row_t r;
    cyc++;
    pop = (mq.size() > 0) && rdy;
    if (!rst_n) begin
      mq.delete();
      m_st = M_IDLE; m_col = 0; m_rowc = 0; m_ovf = 1'b0;
    end else if (fs) begin
      mq.delete();
      m_st = M_FILL; m_col = 0; m_rowc = 0; m_ovf = 1'b0;
      fs_cyc = cyc;
    end else begin
      if (pop) begin
        if (m_st == M_DRAIN && mq[0].row == OROW-1) m_st = M_IDLE;
        void'(mq.pop_front());
      end
      if (ov) begin
        if (m_st != M_FILL) begin
          m_ovf = 1'b1;
        end else begin
          for (int k = 0; k < UF; k++) m_fill[m_col+k] = od[k*BW +: BW];
          m_col += UF;
          if (m_col == OCOL) begin
            m_col = 0;
            for (int c = 0; c < OCOL; c++) r.data[c*BW +: BW] = m_fill[c];
            r.row = m_rowc;
            if (mq.size() < 2) mq.push_back(r);
            else m_ovf = 1'b1;
            if (m_rowc == OROW-1) m_st = M_DRAIN;
            m_rowc++;
          end
        end
      end
    end
  endtask

  task automatic compare_step();
    bit            ev;
    bit            el;
    logic [DW-1:0] ed;
    int            er;
    row_t          o;
    ev = mq.size() > 0;
    ed = ev ? mq[0].data : '0;
    er = ev ? mq[0].row : 0;
    el = ev && (mq[0].row == OROW-1);
    chk("m_valid", DW'(m_valid), DW'(ev));
    chk("m_data", m_data, ed);
    chk("m_row", DW'(m_row), DW'(er));
    chk("m_last", DW'(m_last), DW'(el));
    chk("frame_done", DW'(frame_done), DW'(el && rdy));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    if (m_valid && rdy) begin
      o.data = m_data;
      o.row  = int'(m_row);
      log_q.push_back(o);
    end
    if (frame_done) fd_cnt++;
    if (m_valid && fs_cyc != handled_fs) begin
      first_lat  = cyc - fs_cyc;
      handled_fs = fs_cyc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_step();
  end

  task automatic drive(input bit r, input bit f, input bit v,
                       input logic [UF*BW-1:0] d, input bit rd);
    rst_n = r; fs = f; ov = v; od = d; rdy = rd;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [UF*BW-1:0] beat(input logic [31:0] base, input int b);
    logic [UF*BW-1:0] d;
    for (int k = 0; k < UF; k++) d[k*BW +: BW] = base + 32'(2*b + k);
    return d;
  endfunction

  // Beat b word k = base + 2b + k, and row r holds beats 3r..3r+2, so
  // column c of row r is base + 6r + c.
  function automatic logic [DW-1:0] exp_row(input logic [31:0] base, input int r);
    logic [DW-1:0] d;
    for (int c = 0; c < OCOL; c++) d[c*BW +: BW] = base + 32'(6*r + c);
    return d;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, " m_valid"}, DW'(m_valid), '0);
    chk({tag, " m_data"}, m_data, '0);
    chk({tag, " m_row"}, DW'(m_row), '0);
    chk({tag, " m_last"}, DW'(m_last), '0);
    chk({tag, " frame_done"}, DW'(frame_done), '0);
    chk({tag, " overflow"}, DW'(overflow), '0);
  endtask

  // mode 0: ready always; 1: ready low until the last beat;
  // 2: ready toggles; 3: ready low until the beat that completes row 2
  task automatic run_frame(input logic [31:0] base, input int mode, input string tag);
    int lb;
    int fd0;
    int n;
    int exp_rows[$];
    bit r;
    lb  = log_q.size();
    fd0 = fd_cnt;
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 18; i++) begin
      case (mode)
        1:       r = (i >= 17);
        2:       r = (i % 2 == 1);
        3:       r = (i >= 8);
        default: r = 1'b1;
      endcase
      drive(1, 0, 1, beat(base, i), r);
    end
    repeat (10) drive(1, 0, 0, '0, 1);
    if (mode == 1) exp_rows = '{0, 1, 5};
    else exp_rows = '{0, 1, 2, 3, 4, 5};
    n = log_q.size() - lb;
    chk({tag, " row count"}, DW'(n), DW'(exp_rows.size()));
    for (int i = 0; i < exp_rows.size() && i < n; i++) begin
      chk({tag, " row index"}, DW'(log_q[lb+i].row), DW'(exp_rows[i]));
      chk({tag, " row data"}, log_q[lb+i].data, exp_row(base, exp_rows[i]));
    end
    chk({tag, " frame_done pulses"}, DW'(fd_cnt - fd0), DW'(1));
    chk({tag, " overflow"}, DW'(overflow), DW'(mode == 1));
  endtask

  initial begin
    int pct;
    bit f;
    bit r;
    bit v;
    logic [UF*BW-1:0] d;

    rst_n = 1'b0; fs = 1'b0; ov = 1'b0; od = '0; rdy = 1'b0;
    drive(0, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 0);
    chk_en = 1'b1;
    check_idle_zero("reset");
    drive(1, 0, 0, '0, 1);

    // stray beat while idle, then frame_start clears the flag
    drive(1, 0, 1, beat(32'h1234_0000, 0), 1);
    chk("idle beat overflow", DW'(overflow), DW'(1));
    drive(1, 1, 0, '0, 1);
    chk("frame_start clears overflow", DW'(overflow), DW'(0));

    run_frame(32'h3F80_0000, 0, "basic");
    chk("basic first-row latency", DW'(first_lat), DW'(3));
    run_frame(32'h3F80_0000, 1, "stalled");
    run_frame(32'h3F80_0000, 2, "toggle");
    run_frame(32'h3F80_0000, 3, "pop_and_commit");

    // reset in the middle of a frame
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 7; i++) drive(1, 0, 1, beat(32'h4000_0000, i), 1);
    drive(0, 0, 1, beat(32'h5000_0000, 0), 1);
    check_idle_zero("mid-frame reset");
    drive(0, 0, 0, '0, 1);
    check_idle_zero("held reset");
    repeat (3) drive(1, 0, 0, '0, 1);
    chk("no row after reset", DW'(m_valid), DW'(0));
    run_frame(32'h3F80_0000, 0, "after_reset");

    for (int i = 0; i < 3000; i++) begin
      case ((i / 200) % 4)
        0:       pct = 90;
        1:       pct = 50;
        2:       pct = 20;
        default: pct = 100;
      endcase
      r = ($urandom_range(0, 399) != 0);
      f = (m_st == M_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 99) < 75);
      for (int k = 0; k < UF; k++) d[k*BW +: BW] = $urandom();
      drive(r, f, v, d, $urandom_range(0, 99) < pct);
    end
    repeat (5) drive(1, 0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
